// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a one-entry skid buffer, flush, and
// saturating stall/bubble performance counters.
module pipe_stage_reg #(
  parameter int unsigned       XLEN        = 64,
  parameter int unsigned       CTRL_W      = 24,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter int unsigned       CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_valA,
  input  logic [XLEN-1:0]   in_valB,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_pre_pc,
  input  logic [31:0]       in_instr,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_valA,
  output logic [XLEN-1:0]   out_valB,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_pre_pc,
  output logic [31:0]       out_instr,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]   val_a;
    logic [XLEN-1:0]   val_b;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pre_pc;
    logic [31:0]       instr;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  // EMPTY: M and S free; ONE: M live; FULL: M and S live.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  entry_t             r_m, r_s, w_m_nxt, w_s_nxt;
  entry_t             w_in, w_bubble;
  logic               r_in_ready, r_out_valid;
  logic               w_accept, w_drain;
  logic [CNT_W-1:0]   r_stall_cnt, r_bubble_cnt;

  assign w_in     = '{val_a: in_valA, val_b: in_valB, imm: in_imm, pc: in_pc,
                      pre_pc: in_pre_pc, instr: in_instr, ctrl: in_ctrl};
  assign w_bubble = '{val_a: '0, val_b: '0, imm: '0, pc: '0,
                      pre_pc: '0, instr: '0, ctrl: BUBBLE_CTRL};

  assign w_accept = in_valid & r_in_ready & ~flush;
  assign w_drain  = r_out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_m_nxt     = r_m;
    w_s_nxt     = r_s;
    if (flush) begin
      w_state_nxt = EMPTY;
      w_m_nxt     = w_bubble;
      w_s_nxt     = w_bubble;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_m_nxt     = w_in;
            w_state_nxt = ONE;
          end
        end
        ONE: begin
          if (w_accept && w_drain) begin
            w_m_nxt = w_in;
          end else if (w_accept) begin
            w_s_nxt     = w_in;
            w_state_nxt = FULL;
          end else if (w_drain) begin
            w_m_nxt     = w_bubble;
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (w_drain) begin
            w_m_nxt     = r_s;
            w_s_nxt     = w_bubble;
            w_state_nxt = ONE;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_m_nxt     = w_bubble;
          w_s_nxt     = w_bubble;
        end
      endcase
    end
  end

  // Handshake flags are registered copies of the next state, keeping
  // in_ready free of any combinational path from the ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_m         <= w_bubble;
      r_s         <= w_bubble;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_m         <= w_m_nxt;
      r_s         <= w_s_nxt;
      r_in_ready  <= (w_state_nxt != FULL);
      r_out_valid <= (w_state_nxt != EMPTY);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (r_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (!r_out_valid && (r_bubble_cnt != {CNT_W{1'b1}}))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_valA   = r_m.val_a;
  assign out_valB   = r_m.val_b;
  assign out_imm    = r_m.imm;
  assign out_pc     = r_m.pc;
  assign out_pre_pc = r_m.pre_pc;
  assign out_instr  = r_m.instr;
  assign out_ctrl   = r_m.ctrl;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule
